// File: rtl/audio_fx_pkg.sv
// Shared constants and pot-decoding helpers for the audio effect blocks.
package audio_fx_pkg;

  localparam int unsigned HOLD_BITS_DEFAULT = 6;
  localparam int unsigned DEPTH_MIN_DEFAULT = 2;
  localparam int unsigned POT_W             = 10;

  // Hold factor: one plus the top hold_bits of the pot.
  function automatic int unsigned pot_to_hold(input logic [POT_W-1:0] pot,
                                              input int unsigned     hold_bits);
    return 32'(pot >> (POT_W - hold_bits)) + 32'd1;
  endfunction

  // Retained bits: width minus the top pot nibble, floored at depth_min.
  function automatic int unsigned pot_to_bits(input logic [POT_W-1:0] pot,
                                              input int unsigned     depth_min,
                                              input int unsigned     width);
    int unsigned drop;
    drop = 32'(pot[POT_W-1 -: 4]);
    return (width < drop + depth_min) ? depth_min : width - drop;
  endfunction

endpackage

// File: rtl/bit_quantizer.sv
// Combinational round-half-up to a multiple of 2^drop, with positive saturation.
module bit_quantizer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DW    = 4
) (
  input  logic [WIDTH-1:0] sample_i,
  input  logic [DW-1:0]    drop_i,
  output logic [WIDTH-1:0] quant_c
);

  localparam int unsigned EW = WIDTH + 1;

  logic [EW-1:0] ext_c;
  logic [EW-1:0] half_c;
  logic [EW-1:0] mask_c;
  logic [EW-1:0] sum_c;
  logic          sat_c;

  // One guard bit absorbs the rounding carry; only positive values can overflow.
  always_comb begin
    ext_c  = {sample_i[WIDTH-1], sample_i};
    half_c = '0;
    if (drop_i != '0) begin
      half_c = EW'(1) << (drop_i - DW'(1));
    end
    mask_c  = ~((EW'(1) << drop_i) - EW'(1));
    sum_c   = (ext_c + half_c) & mask_c;
    sat_c   = ~sum_c[EW-1] & sum_c[EW-2];
    quant_c = sat_c ? {1'b0, {(WIDTH-1){1'b1}}} : sum_c[WIDTH-1:0];
  end

endmodule

// File: rtl/audio_bitcrusher.sv
// Sample-and-hold plus bit-depth reduction, two-stage pipeline, settings latched per hold period.
module audio_bitcrusher
  import audio_fx_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned HOLD_BITS = HOLD_BITS_DEFAULT,
  parameter int unsigned DEPTH_MIN = DEPTH_MIN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POT_W-1:0] pot_rate,
  input  logic [POT_W-1:0] pot_depth,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_in_valid,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_out_valid
);

  localparam int unsigned DW = $clog2(WIDTH);
  localparam int unsigned HW = HOLD_BITS + 1;
  localparam int unsigned BW = DW + 1;

  logic [HOLD_BITS-1:0] cnt_q, cnt_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [BW-1:0]        bits_q, bits_d;
  logic [HW-1:0]        pot_hold_c;
  logic [BW-1:0]        pot_bits_c;
  logic                 capture_c;

  logic                 s1_valid_q;
  logic                 s1_cap_q;
  logic [WIDTH-1:0]     s1_sample_q;

  logic [DW-1:0]        drop_c;
  logic [WIDTH-1:0]     quant_c;
  logic [WIDTH-1:0]     held_q;
  logic                 out_valid_q;

  assign pot_hold_c = HW'(pot_to_hold(pot_rate, HOLD_BITS));
  assign pot_bits_c = BW'(pot_to_bits(pot_depth, DEPTH_MIN, WIDTH));
  assign capture_c  = sample_in_valid && (cnt_q == '0);

  // Hold counter and active settings; pots are only sampled on a capture.
  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    bits_d = bits_q;
    if (sample_in_valid) begin
      if (capture_c) begin
        hold_d = pot_hold_c;
        bits_d = pot_bits_c;
        cnt_d  = HOLD_BITS'(pot_hold_c - HW'(1));
      end else begin
        cnt_d  = cnt_q - HOLD_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      hold_q      <= HW'(1);
      bits_q      <= BW'(WIDTH);
      s1_valid_q  <= 1'b0;
      s1_cap_q    <= 1'b0;
      s1_sample_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      bits_q      <= bits_d;
      s1_valid_q  <= sample_in_valid;
      s1_cap_q    <= capture_c;
      s1_sample_q <= sample_in;
    end
  end

  // bits_q already holds the B latched alongside the stage-1 sample.
  assign drop_c = DW'(BW'(WIDTH) - bits_q);

  bit_quantizer #(
    .WIDTH (WIDTH),
    .DW    (DW)
  ) u_quant (
    .sample_i (s1_sample_q),
    .drop_i   (drop_c),
    .quant_c  (quant_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q && s1_cap_q) begin
        held_q <= quant_c;
      end
    end
  end

  assign sample_out       = held_q;
  assign sample_out_valid = out_valid_q;

endmodule

// File: tb/tb_audio_bitcrusher.sv
// Bench for audio_bitcrusher: directed scenarios plus randomized traffic against a behavioural model.
module tb_audio_bitcrusher;

  logic        clk;
  logic        rst;
  logic [9:0]  pot_rate;
  logic [9:0]  pot_depth;
  logic [15:0] sample_in;
  logic        sample_in_valid;
  logic [15:0] sample_out;
  logic        sample_out_valid;

  audio_bitcrusher dut (
    .clk              (clk),
    .rst              (rst),
    .pot_rate         (pot_rate),
    .pot_depth        (pot_depth),
    .sample_in        (sample_in),
    .sample_in_valid  (sample_in_valid),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exq[$];

  // Behavioural model: remaining-hold count, active drop bits, held value.
  int          m_cnt;
  int          m_d;
  logic [15:0] m_held;

  function automatic logic [15:0] mquant(input logic [15:0] s, input int d);
    int v;
    int step;
    v = int'($signed(s));
    if (d == 0) return s;
    step = 1 << d;
    v = v + step / 2;
    v = v - (((v % step) + step) % step);
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_d    = 0;
    m_held = 16'h0000;
  endtask

  // Apply one input for one cycle; exp >= 0 overrides the model's expectation.
  task automatic send(input logic [15:0] s, input int exp = -1);
    exp_t e;
    int   b;
    if (m_cnt == 0) begin
      b = 16 - int'(pot_depth) / 64;
      if (b < 2) b = 2;
      m_d    = 16 - b;
      m_held = mquant(s, m_d);
      m_cnt  = int'(pot_rate) / 16;
    end else begin
      m_cnt--;
    end
    e.data = (exp < 0) ? m_held : 16'(exp);
    e.cyc  = cyc + 2;
    exq.push_back(e);
    sample_in       = s;
    sample_in_valid = 1'b1;
    @(negedge clk);
    sample_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Output monitor: every strobe must match the oldest pending expectation on time.
  always @(negedge clk) begin
    if (rst && sample_out_valid) begin
      if (exq.size() == 0) begin
        check("spurious_vld", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exq.pop_front();
        check("data", 32'(sample_out), 32'(e.data));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst             = 1'b0;
    pot_rate        = '0;
    pot_depth       = '0;
    sample_in       = '0;
    sample_in_valid = 1'b0;
    model_reset();
    idle(3);
    check("rst_out", 32'(sample_out), 32'd0);
    check("rst_vld", 32'(sample_out_valid), 32'd0);
    #2 rst = 1'b1;
    idle(2);

    // Passthrough, spaced inputs
    send(16'h0100, 16'h0100); idle(2);
    send(16'h0200, 16'h0200); idle(2);
    send(16'h8000, 16'h8000); idle(3);

    // Hold factor 2
    pot_rate = 10'd16;
    send(16'h0100, 16'h0100);
    send(16'h0200, 16'h0100);
    send(16'h0300, 16'h0300);
    send(16'h0400, 16'h0300);
    idle(3);

    // Two retained bits with rounding and saturation
    pot_rate  = 10'd0;
    pot_depth = 10'h380;
    send(16'h3000, 16'h4000);
    send(16'h9000, 16'h8000);
    send(16'h7000, 16'h7FFF);
    send(16'h1FFF, 16'h0000);
    idle(3);

    // Pot change mid-hold waits for the next capture
    pot_depth = 10'd0;
    pot_rate  = 10'd48;
    send(16'h0A00, 16'h0A00);
    send(16'h0B00, 16'h0A00);
    pot_rate = 10'd0;
    send(16'h0C00, 16'h0A00);
    send(16'h0D00, 16'h0A00);
    send(16'h0E00, 16'h0E00);
    send(16'h0F00, 16'h0F00);
    idle(3);

    // Back-to-back ramp
    for (int i = 0; i < 20; i++) send(16'(16'h0040 + i), 16'h0040 + i);
    idle(3);

    // Asynchronous reset mid-hold with samples in flight
    pot_rate = 10'd112;
    send(16'h1111);
    send(16'h2222);
    send(16'h3333);
    check("pre_rst_out", 32'(sample_out), 32'h1111);
    #2 rst = 1'b0;
    #1;
    check("rst_async_out", 32'(sample_out), 32'd0);
    check("rst_async_vld", 32'(sample_out_valid), 32'd0);
    exq.delete();
    model_reset();
    pot_rate = 10'd0;
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_vld", 32'(sample_out_valid), 32'd0);
      check("post_rst_out", 32'(sample_out), 32'd0);
    end
    send(16'h1234, 16'h1234);
    idle(3);

    // Randomized traffic with random pot moves and gaps
    for (int i = 0; i < 400; i++) begin
      logic [15:0] s;
      if ($urandom_range(0, 5) == 0) begin
        pot_rate  = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(0, 127));
        pot_depth = ($urandom_range(0, 4) == 0) ? 10'h3FF : 10'($urandom);
      end
      case ($urandom_range(0, 7))
        0:       s = 16'h7FFF;
        1:       s = 16'h8000;
        default: s = 16'($urandom);
      endcase
      send(s);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(5);
    check("drain", 32'(exq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
